rf_read_arbiter: RTL and testbench

//  Shares NUM_RDPORT integer-regfile read ports among NUM_REQ issue slots (issue-queue outputs).

---
 rtl/rf_read_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_read_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares the integer-regfile read ports among issue slots.
// Each cycle, every slot is granted either all of its source reads or none.
// Arbitration is combinational and drives the read ports in the same cycle.
// Finished/replay feedback and the IQ entry index are registered and appear
// one non-stalled cycle later. A denied slot becomes top priority next cycle.
module rf_read_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_SRCS   = 2,
  parameter  int NUM_RDPORT = 6,
  parameter  int IQIDX_W    = 3,
  parameter  int PREG_W     = 7,
  localparam int OWN_W      = $clog2(NUM_REQ * NUM_SRCS)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_stall,
  input  logic [NUM_REQ-1:0]                          i_req_vld,
  input  logic [NUM_REQ-1:0][IQIDX_W-1:0]             i_req_iqidx,
  input  logic [NUM_REQ-1:0][NUM_SRCS-1:0]            i_req_src_need,
  input  logic [NUM_REQ-1:0][NUM_SRCS-1:0][PREG_W-1:0] i_req_prs,
  output logic [NUM_RDPORT-1:0]                       o_rd_en,
  output logic [NUM_RDPORT-1:0][PREG_W-1:0]           o_rd_addr,
  output logic [NUM_RDPORT-1:0][OWN_W-1:0]            o_rd_owner,
  output logic [NUM_REQ-1:0]                          o_finished_vec,
  output logic [NUM_REQ-1:0]                          o_replay_vec,
  output logic [NUM_REQ-1:0][IQIDX_W-1:0]             o_feedback_idx,
  output logic [15:0]                                 o_replay_cnt
);

  localparam int SLOT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SRC_W  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int NEED_W = $clog2(NUM_SRCS + 1);
  localparam int PORT_W = $clog2(NUM_RDPORT + 1);

  // Registered state
  logic [SLOT_W-1:0]             r_rr_ptr;
  logic [NUM_REQ-1:0]            r_finished;
  logic [NUM_REQ-1:0]            r_replay;
  logic [NUM_REQ-1:0][IQIDX_W-1:0] r_fb_idx;
  logic [15:0]                   r_replay_cnt;

  // Combinational arbitration results
  logic [NUM_REQ-1:0]                w_grant;
  logic [NUM_RDPORT-1:0]             w_rd_en;
  logic [NUM_RDPORT-1:0][PREG_W-1:0] w_rd_addr;
  logic [NUM_RDPORT-1:0][OWN_W-1:0]  w_rd_owner;
  logic                              w_any_deny;
  logic [SLOT_W-1:0]                 w_first_deny;
  logic [NUM_REQ-1:0]                w_replay;
  logic [SLOT_W-1:0]                 w_rr_next;
  logic [16:0]                       w_cnt_sum;
  logic [15:0]                       w_cnt_next;

  // Round-robin all-or-nothing grant and in-order port fill starting at r_rr_ptr
  always_comb begin
    logic [SLOT_W-1:0] w_slot;
    logic [NEED_W-1:0] w_need;
    logic [PORT_W-1:0] w_port;
    // NOTE: every output of this block gets a default up front so no path leaves
    // one unassigned (which would infer a latch); blocking '=' is correct here
    // because later statements must see the running port index.
    w_grant      = '0;
    w_rd_en      = '0;
    w_rd_addr    = '0;
    w_rd_owner   = '0;
    w_any_deny   = 1'b0;
    w_first_deny = '0;
    w_slot       = '0;
    w_need       = '0;
    w_port       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_slot = SLOT_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      w_need = NEED_W'($countones(i_req_src_need[w_slot]));
      if (i_req_vld[w_slot]) begin
        if (int'(w_port) + int'(w_need) <= NUM_RDPORT) begin
          w_grant[w_slot] = 1'b1;
          for (int s = 0; s < NUM_SRCS; s++) begin
            if (i_req_src_need[w_slot][SRC_W'(s)]) begin
              w_rd_en[w_port]    = 1'b1;
              w_rd_addr[w_port]  = i_req_prs[w_slot][SRC_W'(s)];
              w_rd_owner[w_port] = OWN_W'(int'(w_slot) * NUM_SRCS + s);
              w_port             = w_port + 1'b1;
            end
          end
        end else if (!w_any_deny) begin
          w_any_deny   = 1'b1;
          w_first_deny = w_slot;
        end
      end
    end
    // Stall or reset: no port activity and no grants this cycle
    if (rst || i_stall) begin
      w_grant    = '0;
      w_rd_en    = '0;
      w_rd_addr  = '0;
      w_rd_owner = '0;
    end
  end

  // Next-state terms for the feedback registers, pointer and saturating counter
  always_comb begin
    w_replay   = i_req_vld & ~w_grant;
    w_rr_next  = w_any_deny ? w_first_deny : SLOT_W'((int'(r_rr_ptr) + 1) % NUM_REQ);
    w_cnt_sum  = 17'(r_replay_cnt) + 17'($countones(w_replay));
    w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  // Feedback, priority pointer and replay counter; all hold while stalled
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and sampled only on the clock edge; state uses
    // non-blocking '<=' so every register samples pre-edge values.
    if (rst) begin
      r_rr_ptr     <= '0;
      r_finished   <= '0;
      r_replay     <= '0;
      r_fb_idx     <= '0;
      r_replay_cnt <= '0;
    end else if (!i_stall) begin
      r_rr_ptr     <= w_rr_next;
      r_finished   <= w_grant;
      r_replay     <= w_replay;
      r_fb_idx     <= i_req_iqidx;
      r_replay_cnt <= w_cnt_next;
    end
  end

  assign o_rd_en        = w_rd_en;
  assign o_rd_addr      = w_rd_addr;
  assign o_rd_owner     = w_rd_owner;
  assign o_finished_vec = r_finished;
  assign o_replay_vec   = r_replay;
  assign o_feedback_idx = r_fb_idx;
  assign o_replay_cnt   = r_replay_cnt;

  // Sanity checks on port usage, per-slot need and address integrity
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(o_rd_en) <= NUM_RDPORT);
      assert ((o_finished_vec & o_replay_vec) == '0);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_need_chk
    // Need is bounded by the number of source operands
    always_ff @(posedge clk) begin
      if (!rst && i_req_vld[g]) assert ($countones(i_req_src_need[g]) <= NUM_SRCS);
    end
  end

  for (genvar g = 0; g < NUM_RDPORT; g++) begin : g_addr_chk
    // An active read port never carries an unknown address
    always_ff @(posedge clk) begin
      if (!rst && o_rd_en[g]) assert (!$isunknown(o_rd_addr[g]));
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench for rf_read_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_rf_read_arbiter;

  localparam int NR = 4;
  localparam int NS = 2;
  localparam int NP = 6;
  localparam int IW = 3;
  localparam int PW = 7;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [NR-1:0]               vld;
  logic [NR-1:0][IW-1:0]       iqidx;
  logic [NR-1:0][NS-1:0]       need;
  logic [NR-1:0][NS-1:0][PW-1:0] prs;

  logic [NP-1:0]           rd_en;
  logic [NP-1:0][PW-1:0]   rd_addr;
  logic [NP-1:0][OW-1:0]   rd_owner;
  logic [NR-1:0]           fin_vec;
  logic [NR-1:0]           rep_vec;
  logic [NR-1:0][IW-1:0]   fb_idx;
  logic [15:0]             rep_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int                    m_rr;
  logic [NR-1:0]         m_fin;
  logic [NR-1:0]         m_rep;
  logic [NR-1:0][IW-1:0] m_idx;
  int                    m_cnt;

  // Expected combinational outputs for the current inputs
  logic [NP-1:0]         e_en;
  logic [NP-1:0][PW-1:0] e_addr;
  logic [NP-1:0][OW-1:0] e_own;
  logic [NR-1:0]         e_grant;
  int                    e_rr_next;

  always #5 clk = ~clk;

  rf_read_arbiter #(
    .NUM_REQ(NR), .NUM_SRCS(NS), .NUM_RDPORT(NP), .IQIDX_W(IW), .PREG_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .i_stall(stall),
    .i_req_vld(vld), .i_req_iqidx(iqidx), .i_req_src_need(need), .i_req_prs(prs),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_rd_owner(rd_owner),
    .o_finished_vec(fin_vec), .o_replay_vec(rep_vec), .o_feedback_idx(fb_idx),
    .o_replay_cnt(rep_cnt)
  );

  // Model: walk slots from the priority pointer, grant whole slots while ports
  // remain, and list granted (slot,src) reads in order; list position = port.
  task automatic model_arb();
    int rem, n, fd;
    bit den;
    int qs[$];
    int qc[$];
    logic [1:0] r;
    logic [2:0] pi;
    rem = NP; den = 1'b0; fd = 0;
    e_grant = '0; e_en = '0; e_addr = '0; e_own = '0;
    for (int k = 0; k < NR; k++) begin
      r = 2'((m_rr + k) % NR);
      n = $countones(need[r]);
      if (vld[r]) begin
        if (n <= rem) begin
          e_grant[r] = 1'b1;
          rem -= n;
          for (int s = 0; s < NS; s++)
            if (need[r][1'(s)]) begin qs.push_back(int'(r)); qc.push_back(s); end
        end else if (!den) begin
          den = 1'b1;
          fd  = int'(r);
        end
      end
    end
    for (int p = 0; p < qs.size(); p++) begin
      pi = 3'(p);
      e_en[pi]   = 1'b1;
      e_addr[pi] = prs[2'(qs[p])][1'(qc[p])];
      e_own[pi]  = 3'(qs[p] * NS + qc[p]);
    end
    if (stall || rst) begin
      e_en = '0; e_addr = '0; e_own = '0; e_grant = '0;
    end
    e_rr_next = den ? fd : (m_rr + 1) % NR;
  endtask

  task automatic model_clk();
    if (rst) begin
      m_rr = 0; m_fin = '0; m_rep = '0; m_idx = '0; m_cnt = 0;
    end else if (!stall) begin
      m_fin = e_grant;
      m_rep = vld & ~e_grant;
      m_idx = iqidx;
      m_cnt = m_cnt + $countones(m_rep);
      if (m_cnt > 65535) m_cnt = 65535;
      m_rr  = e_rr_next;
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0][NS-1:0] nd,
                       input logic [NR-1:0][IW-1:0] ix,
                       input logic [NR-1:0][NS-1:0][PW-1:0] pr, input logic st);
    @(negedge clk);
    vld = v; need = nd; iqidx = ix; prs = pr; stall = st;
    #1;
    model_arb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  function automatic logic [NR-1:0][NS-1:0][PW-1:0] rnd_prs();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(4'hF, 8'hFF, 12'hABC, rnd_prs(), 1'b0);
    n_vec++; if (rd_en !== 6'h00) begin n_err++; $display("FAIL reset_rd_en got %h exp 00", rd_en); end
    tick();
    tick();
    n_vec++; if (fin_vec !== 4'h0) begin n_err++; $display("FAIL reset_fin got %b exp 0000", fin_vec); end
    n_vec++; if (rep_vec !== 4'h0) begin n_err++; $display("FAIL reset_rep got %b exp 0000", rep_vec); end
    n_vec++; if (fb_idx !== 12'h000) begin n_err++; $display("FAIL reset_idx got %h exp 000", fb_idx); end
    n_vec++; if (rep_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_cnt got %h exp 0000", rep_cnt); end
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'h0, 8'h00, 12'h000, '0, 1'b0);
      tick();
    end
  endtask

  task automatic test_directed();
    logic [NR-1:0][NS-1:0][PW-1:0] pr;
    // T1: three slots need 2 each from pointer 0
    pr = rnd_prs();
    drive(4'b0111, 8'hFF, 12'h321, pr, 1'b0);
    n_vec++; if (rd_en !== 6'h3F) begin n_err++; $display("FAIL t1_rd_en got %h exp 3f", rd_en); end
    n_vec++; if (rd_owner !== {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin n_err++; $display("FAIL t1_owner got %h", rd_owner); end
    n_vec++; if (rd_addr[5] !== pr[2][1]) begin n_err++; $display("FAIL t1_addr5 got %h exp %h", rd_addr[5], pr[2][1]); end
    tick();
    n_vec++; if (fin_vec !== 4'b0111) begin n_err++; $display("FAIL t1_fin got %b exp 0111", fin_vec); end
    n_vec++; if (rep_vec !== 4'b0000) begin n_err++; $display("FAIL t1_rep got %b exp 0000", rep_vec); end
    // Pointer is now 1; three empty cycles bring it back to 0
    idle_cycles(3);
    // T2: four slots need 2 -> slot 3 denied
    pr = rnd_prs();
    drive(4'b1111, 8'hFF, 12'h765, pr, 1'b0);
    n_vec++; if (rd_owner !== {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin n_err++; $display("FAIL t2_owner got %h", rd_owner); end
    tick();
    n_vec++; if (rep_vec !== 4'b1000) begin n_err++; $display("FAIL t2_rep got %b exp 1000", rep_vec); end
    n_vec++; if (fin_vec !== 4'b0111) begin n_err++; $display("FAIL t2_fin got %b exp 0111", fin_vec); end
    n_vec++; if (rep_cnt !== 16'd1) begin n_err++; $display("FAIL t2_cnt got %0d exp 1", rep_cnt); end
    n_vec++; if (fb_idx !== 12'h765) begin n_err++; $display("FAIL t2_idx got %h exp 765", fb_idx); end
    // T3: same request; slot 3 now first
    drive(4'b1111, 8'hFF, 12'h765, pr, 1'b0);
    n_vec++; if (rd_owner !== {3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6}) begin n_err++; $display("FAIL t3_owner got %h", rd_owner); end
    n_vec++; if (rd_addr[0] !== pr[3][0]) begin n_err++; $display("FAIL t3_addr0 got %h exp %h", rd_addr[0], pr[3][0]); end
    tick();
    n_vec++; if (rep_vec !== 4'b0100) begin n_err++; $display("FAIL t3_rep got %b exp 0100", rep_vec); end
    n_vec++; if (fin_vec !== 4'b1011) begin n_err++; $display("FAIL t3_fin got %b exp 1011", fin_vec); end
    n_vec++; if (rep_cnt !== 16'd2) begin n_err++; $display("FAIL t3_cnt got %0d exp 2", rep_cnt); end
    // Pointer is now 2; two empty cycles return it to 0
    idle_cycles(2);
    // T4: needs {2,1,2,2}; slot 3 denied, one port idle
    pr = rnd_prs();
    drive(4'b1111, {2'b11, 2'b11, 2'b01, 2'b11}, 12'h111, pr, 1'b0);
    n_vec++; if (rd_en !== 6'b011111) begin n_err++; $display("FAIL t4_rd_en got %b exp 011111", rd_en); end
    n_vec++; if (rd_owner !== {3'd0, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0}) begin n_err++; $display("FAIL t4_owner got %h", rd_owner); end
    n_vec++; if (rd_addr[5] !== 7'd0) begin n_err++; $display("FAIL t4_idle_addr got %h exp 0", rd_addr[5]); end
    tick();
    n_vec++; if (rep_vec !== 4'b1000) begin n_err++; $display("FAIL t4_rep got %b exp 1000", rep_vec); end
    n_vec++; if (rep_cnt !== 16'd3) begin n_err++; $display("FAIL t4_cnt got %0d exp 3", rep_cnt); end
  endtask

  task automatic test_stall();
    logic [NR-1:0][IW-1:0] ix0;
    logic [15:0] cnt0;
    ix0  = 12'h5A3;
    drive(4'b0011, 8'hFF, ix0, rnd_prs(), 1'b0);
    tick();
    cnt0 = 16'(m_cnt);
    n_vec++; if (fin_vec !== 4'b0011) begin n_err++; $display("FAIL stall_pre_fin got %b exp 0011", fin_vec); end
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 8'(($urandom() & 32'hFF) | 32'h33), 12'($urandom()), rnd_prs(), 1'b1);
      n_vec++; if (rd_en !== 6'h00) begin n_err++; $display("FAIL stall_rd_en got %h exp 00", rd_en); end
      tick();
      n_vec++; if (fin_vec !== 4'b0011) begin n_err++; $display("FAIL stall_fin got %b exp 0011", fin_vec); end
      n_vec++; if (rep_vec !== 4'b0000) begin n_err++; $display("FAIL stall_rep got %b exp 0000", rep_vec); end
      n_vec++; if (fb_idx !== ix0) begin n_err++; $display("FAIL stall_idx got %h exp %h", fb_idx, ix0); end
      n_vec++; if (rep_cnt !== cnt0) begin n_err++; $display("FAIL stall_cnt got %0d exp %0d", rep_cnt, cnt0); end
    end
    drive(4'h0, 8'h00, 12'h000, '0, 1'b0);
    n_vec++; if (fin_vec !== 4'b0011) begin n_err++; $display("FAIL unstall_fin got %b exp 0011", fin_vec); end
    n_vec++; if (fb_idx !== ix0) begin n_err++; $display("FAIL unstall_idx got %h exp %h", fb_idx, ix0); end
    tick();
    n_vec++; if (fin_vec !== 4'b0000) begin n_err++; $display("FAIL unstall_next_fin got %b exp 0000", fin_vec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom()), 8'($urandom()), 12'($urandom()), rnd_prs(),
            ($urandom_range(0, 6) == 0));
      n_vec++; if (rd_en !== e_en) begin n_err++; $display("FAIL rnd_rd_en got %b exp %b", rd_en, e_en); end
      n_vec++; if (rd_addr !== e_addr) begin n_err++; $display("FAIL rnd_rd_addr got %h exp %h", rd_addr, e_addr); end
      n_vec++; if (rd_owner !== e_own) begin n_err++; $display("FAIL rnd_owner got %h exp %h", rd_owner, e_own); end
      tick();
      n_vec++; if (fin_vec !== m_fin) begin n_err++; $display("FAIL rnd_fin got %b exp %b", fin_vec, m_fin); end
      n_vec++; if (rep_vec !== m_rep) begin n_err++; $display("FAIL rnd_rep got %b exp %b", rep_vec, m_rep); end
      n_vec++; if (fb_idx !== m_idx) begin n_err++; $display("FAIL rnd_idx got %h exp %h", fb_idx, m_idx); end
      n_vec++; if (rep_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt got %0d exp %0d", rep_cnt, m_cnt); end
    end
  endtask

  task automatic test_saturation();
    // One replay per cycle: four slots needing two reads each
    for (int i = 0; i < 66000; i++) begin
      drive(4'hF, 8'hFF, 12'($urandom()), rnd_prs(), 1'b0);
      tick();
    end
    n_vec++; if (rep_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt got %h exp ffff", rep_cnt); end
    n_vec++; if (rep_vec !== m_rep) begin n_err++; $display("FAIL sat_rep got %b exp %b", rep_vec, m_rep); end
    // Reset in the middle of traffic drops pending feedback
    rst = 1'b1;
    drive(4'hF, 8'hFF, 12'hFFF, rnd_prs(), 1'b0);
    n_vec++; if (rd_en !== 6'h00) begin n_err++; $display("FAIL midrst_rd_en got %h exp 00", rd_en); end
    tick();
    n_vec++; if (fin_vec !== 4'h0) begin n_err++; $display("FAIL midrst_fin got %b exp 0000", fin_vec); end
    n_vec++; if (rep_vec !== 4'h0) begin n_err++; $display("FAIL midrst_rep got %b exp 0000", rep_vec); end
    n_vec++; if (fb_idx !== 12'h000) begin n_err++; $display("FAIL midrst_idx got %h exp 000", fb_idx); end
    n_vec++; if (rep_cnt !== 16'h0000) begin n_err++; $display("FAIL midrst_cnt got %h exp 0000", rep_cnt); end
    rst = 1'b0;
    // Pointer back at 0: slot 0 owns port 0, slot 3 is the one denied
    drive(4'hF, 8'hFF, 12'h246, rnd_prs(), 1'b0);
    n_vec++; if (rd_owner[0] !== 3'd0) begin n_err++; $display("FAIL postrst_owner0 got %0d exp 0", rd_owner[0]); end
    tick();
    n_vec++; if (rep_vec !== 4'b1000) begin n_err++; $display("FAIL postrst_rep got %b exp 1000", rep_vec); end
    n_vec++; if (rep_cnt !== 16'd1) begin n_err++; $display("FAIL postrst_cnt got %0d exp 1", rep_cnt); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; vld = '0; need = '0; iqidx = '0; prs = '0;
    m_rr = 0; m_fin = '0; m_rep = '0; m_idx = '0; m_cnt = 0;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
